// File: rtl/fib_engine.sv
// Iterative Fibonacci engine with a start/busy/done handshake.
// Adds one term per clock and saturates the result to all-ones on overflow.
module fib_engine #(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] fib,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] fib_q, fib_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W:0]   sum_s;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            cnt_q   <= {N_W{1'b0}};
            fib_q   <= {DATA_W{1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            fib_q   <= fib_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept, iterate, terminate on count or overflow
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        fib_d   = fib_q;
        ovf_d   = ovf_q;
        sum_s   = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    fib_d = {DATA_W{1'b0}};
                    ovf_d = 1'b0;
                    if (n == {N_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else if (n <= N_W'(2)) begin
                        state_d = S_DONE;
                        fib_d   = DATA_W'(1);
                    end else begin
                        state_d = S_CALC;
                        a_d     = DATA_W'(1);
                        b_d     = DATA_W'(1);
                        cnt_d   = n - N_W'(2);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_CALC: begin
                a_d   = b_q;
                b_d   = sum_s[DATA_W-1:0];
                cnt_d = cnt_q - N_W'(1);
                // The carry-out marks the first index that no longer fits
                if (sum_s[DATA_W]) begin
                    state_d = S_DONE;
                    fib_d   = {DATA_W{1'b1}};
                    ovf_d   = 1'b1;
                end else if (cnt_q == N_W'(1)) begin
                    state_d = S_DONE;
                    fib_d   = sum_s[DATA_W-1:0];
                end else begin
                    state_d = S_CALC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fib      = fib_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fib_engine.sv
// Self-checking bench for fib_engine: a 32-bit and a 16-bit instance compared
// every cycle against a sequence-level model, plus directed literal expectations.
module tb_fib_engine;

    logic        clk;
    logic        rst_n;
    logic        st   [2];
    logic [7:0]  nn   [2];
    logic        busy0, done0, ovf0;
    logic [31:0] fib0;
    logic        busy1, done1, ovf1;
    logic [15:0] fib1;

    int m_tot, m_pass, d_tot, d_pass;

    // model state per instance
    bit     m_busy [2];
    bit     m_done [2];
    bit     m_ovf  [2];
    longint m_fib  [2];
    int     m_rem  [2];
    longint m_res  [2];
    bit     m_rovf [2];
    int     w_of   [2];

    fib_engine #(.DATA_W(32), .N_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .n(nn[0]),
        .busy(busy0), .done(done0), .fib(fib0), .overflow(ovf0)
    );

    fib_engine #(.DATA_W(16), .N_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .n(nn[1]),
        .busy(busy1), .done(done1), .fib(fib1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fibonacci from first principles: result, overflow and CALC edges needed
    function automatic void ref_calc(input int nv, input int w, output longint res,
                                     output bit ovf, output int edges);
        longint lim, a, b, s;
        lim = longint'(1) << w;
        res = 0; ovf = 1'b0; edges = 0;
        if (nv == 0) begin
            res = 0;
        end else if (nv <= 2) begin
            res = 1;
        end else begin
            a = 1; b = 1;
            for (int k = 3; k <= nv; k++) begin
                s = a + b;
                if (s >= lim) begin
                    res = lim - 1; ovf = 1'b1; edges = k - 2;
                    return;
                end
                a = b; b = s;
            end
            res = b; edges = nv - 2;
        end
    endfunction

    // Behavioural model advanced on the same edges as the DUT
    always @(posedge clk or negedge rst_n) begin
        longint r;
        bit     o;
        int     e;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_ovf[i] = 1'b0;
                m_fib[i] = 0; m_rem[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 1'b0; m_done[i] = 1'b1;
                        m_fib[i] = m_res[i]; m_ovf[i] = m_rovf[i];
                    end
                end else if (st[i] === 1'b1) begin
                    ref_calc(int'(nn[i]), w_of[i], r, o, e);
                    if (e == 0) begin
                        m_busy[i] = 1'b0; m_done[i] = 1'b1; m_fib[i] = r; m_ovf[i] = o;
                    end else begin
                        m_busy[i] = 1'b1; m_done[i] = 1'b0; m_fib[i] = 0; m_ovf[i] = 1'b0;
                        m_rem[i] = e; m_res[i] = r; m_rovf[i] = o;
                    end
                end
            end
        end
    end

    task automatic chk_m(input string nm, input int i, input logic [63:0] act,
                         input logic [63:0] exp);
        m_tot++;
        if (act !== exp)
            $display("FAIL %s[%0d] t=%0t: got %0d expected %0d", nm, i, $time, act, exp);
        else
            m_pass++;
    endtask

    task automatic chk_d(input string nm, input logic [63:0] act, input logic [63:0] exp);
        d_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            d_pass++;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk_m("busy", 0, {63'b0, busy0}, {63'b0, m_busy[0]});
        chk_m("done", 0, {63'b0, done0}, {63'b0, m_done[0]});
        chk_m("fib",  0, {32'b0, fib0},  m_fib[0]);
        chk_m("ovf",  0, {63'b0, ovf0},  {63'b0, m_ovf[0]});
        chk_m("busy", 1, {63'b0, busy1}, {63'b0, m_busy[1]});
        chk_m("done", 1, {63'b0, done1}, {63'b0, m_done[1]});
        chk_m("fib",  1, {48'b0, fib1},  m_fib[1]);
        chk_m("ovf",  1, {63'b0, ovf1},  {63'b0, m_ovf[1]});
    end

    function automatic logic dn(input int i);
        return (i == 0) ? done0 : done1;
    endfunction

    function automatic logic [63:0] fb(input int i);
        return (i == 0) ? {32'b0, fib0} : {48'b0, fib1};
    endfunction

    function automatic logic ov(input int i);
        return (i == 0) ? ovf0 : ovf1;
    endfunction

    // Count edges after the accepting edge until done, bounded
    task automatic wait_done(input int i, input int start_edges, output int edges);
        edges = start_edges;
        while (dn(i) !== 1'b1 && edges < 400) begin
            @(posedge clk); #2;
            edges++;
        end
    endtask

    task automatic req(input int i, input int nv, input logic [63:0] exp_fib,
                       input bit exp_ovf, input int exp_edges, input string nm);
        int edges;
        @(posedge clk); #2;
        st[i] = 1'b1; nn[i] = 8'(nv);
        @(posedge clk); #2;
        st[i] = 1'b0;
        wait_done(i, 0, edges);
        chk_d({nm, "_edges"}, 64'(edges), 64'(exp_edges));
        chk_d({nm, "_fib"}, fb(i), exp_fib);
        chk_d({nm, "_ovf"}, {63'b0, ov(i)}, {63'b0, exp_ovf});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint r;
        bit     o;
        int     e;
        int     edges;
        m_tot = 0; m_pass = 0; d_tot = 0; d_pass = 0;
        w_of[0] = 32; w_of[1] = 16;
        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0; nn[0] = 8'd0; nn[1] = 8'd0;

        ref_calc(47, 32, r, o, e);
        chk_d("model_f47", 64'(r), 64'd2971215073);
        ref_calc(25, 16, r, o, e);
        chk_d("model_f25_w16_edges", 64'(e), 64'd23);

        #12;
        chk_d("rst_busy", {63'b0, busy0}, 64'd0);
        chk_d("rst_done", {63'b0, done0}, 64'd0);
        chk_d("rst_fib",  {32'b0, fib0},  64'd0);
        chk_d("rst_ovf",  {63'b0, ovf0},  64'd0);
        #10;
        rst_n = 1'b1;

        req(0, 47, 64'd2971215073, 1'b0, 45, "n47");
        req(0, 10, 64'd55, 1'b0, 8, "n10");
        req(0, 0, 64'd0, 1'b0, 0, "n0");
        req(0, 1, 64'd1, 1'b0, 0, "n1");
        req(0, 2, 64'd1, 1'b0, 0, "n2");
        req(0, 48, 64'hFFFF_FFFF, 1'b1, 46, "n48");
        req(0, 255, 64'hFFFF_FFFF, 1'b1, 46, "n255");
        req(1, 24, 64'd46368, 1'b0, 22, "w16_n24");
        req(1, 25, 64'hFFFF, 1'b1, 23, "w16_n25");

        // second start during CALC must be ignored
        @(posedge clk); #2;
        st[0] = 1'b1; nn[0] = 8'd20;
        @(posedge clk); #2;
        st[0] = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        st[0] = 1'b1; nn[0] = 8'd5;
        @(posedge clk); #2;
        st[0] = 1'b0;
        wait_done(0, 3, edges);
        chk_d("ign_edges", 64'(edges), 64'd18);
        chk_d("ign_fib", {32'b0, fib0}, 64'd6765);

        req(0, 5, 64'd5, 1'b0, 3, "restart_n5");

        // asynchronous abort mid-CALC
        @(posedge clk); #2;
        st[0] = 1'b1; nn[0] = 8'd40;
        @(posedge clk); #2;
        st[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_d("abort_busy", {63'b0, busy0}, 64'd0);
        chk_d("abort_done", {63'b0, done0}, 64'd0);
        chk_d("abort_fib",  {32'b0, fib0},  64'd0);
        chk_d("abort_ovf",  {63'b0, ovf0},  64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        req(0, 12, 64'd144, 1'b0, 10, "after_rst_n12");

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", m_pass + d_pass, m_tot + d_tot);
        $finish;
    end

endmodule
